// File: rtl/piksel_okuyucu_pkg.sv
// Shared state encoding and word-packing constants for the piksel_okuyucu pixel streamer.
package piksel_okuyucu_pkg;

    localparam int unsigned PIXEL_PER_WORD = 4;
    localparam int unsigned WORD_W         = 32;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        OKU   = 2'd1,
        BITTI = 2'd2
    } durum_t;

    function automatic int unsigned kelime_sayisi(input int unsigned n);
        return (n + PIXEL_PER_WORD - 1) / PIXEL_PER_WORD;
    endfunction

endpackage

// File: rtl/piksel_okuyucu_fifo.sv
// Two-entry synchronous word FIFO; a push and a pop in the same cycle leave the fill count unchanged.
module piksel_okuyucu_fifo
    import piksel_okuyucu_pkg::*;
#(
    parameter int unsigned DW = WORD_W
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          push_i,
    input  logic [DW-1:0] veri_i,
    input  logic          pop_i,
    output logic [DW-1:0] bas_o,
    output logic [1:0]    doluluk_o,
    output logic          bos_o
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [1:0]    fill_q, fill_d;
    logic          push_ok, pop_ok;

    always_comb begin
        pop_ok  = pop_i && (fill_q != 2'd0);
        push_ok = push_i && ((fill_q != 2'd2) || pop_ok);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        fill_d  = fill_q;
        if (push_ok) begin
            mem_d[wr_q] = veri_i;
            wr_d        = ~wr_q;
        end
        if (pop_ok) begin
            rd_d = ~rd_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            fill_q   <= '0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fill_q <= fill_d;
        end
    end

    assign bas_o     = mem_q[rd_q];
    assign doluluk_o = fill_q;
    assign bos_o     = (fill_q == 2'd0);

endmodule

// File: rtl/piksel_okuyucu.sv
// Streams a GENISLIK x YUKSEKLIK image from a word-wide SRAM as one pixel per cycle with stall support.
// Optional row-end marker output satir_sonu_o is enabled by defining PIXEL_OKUYUCU_SATIR_ISARET_EN.
module piksel_okuyucu
    import piksel_okuyucu_pkg::*;
#(
    parameter int unsigned GENISLIK  = 8,
    parameter int unsigned YUKSEKLIK = 8,
    parameter int unsigned ADR_W     = 16,
    parameter int unsigned PIXEL_W   = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               basla_i,
    input  logic [ADR_W-1:0]   taban_adr_i,
    input  logic               stal_i,
    output logic               csb_o,
    output logic [ADR_W-1:0]   addr_o,
    input  logic [WORD_W-1:0]  dout_i,
    output logic               etkin_o,
    output logic [PIXEL_W-1:0] pixel_o,
    output logic               mesgul_o,
`ifdef PIXEL_OKUYUCU_SATIR_ISARET_EN
    output logic               satir_sonu_o,
`endif
    output logic               bitti_o
);

    localparam int unsigned N    = GENISLIK * YUKSEKLIK;
    localparam int unsigned W    = kelime_sayisi(N);
    localparam int unsigned PC_W = $clog2(N + 1);
    localparam int unsigned WC_W = $clog2(W + 1);

    durum_t             durum_q, durum_d;
    logic [ADR_W-1:0]   base_q, base_d;
    logic [WC_W-1:0]    word_idx_q, word_idx_d;
    logic               inflight_q, inflight_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [PC_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic               etkin_q, etkin_d;
    logic [PIXEL_W-1:0] pixel_q, pixel_d;

    logic [WORD_W-1:0]  fifo_bas;
    logic [1:0]         fifo_fill;
    logic               fifo_bos;
    logic               fifo_pop;
    logic               basla_kabul, okuma, yukle, son_tuketim;

    piksel_okuyucu_fifo #(.DW(WORD_W)) u_fifo (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .push_i    (inflight_q),
        .veri_i    (dout_i),
        .pop_i     (fifo_pop),
        .bas_o     (fifo_bas),
        .doluluk_o (fifo_fill),
        .bos_o     (fifo_bos)
    );

    // A read counts against FIFO space from issue, so buffered plus in-flight words never exceed two.
    always_comb begin
        basla_kabul = (durum_q == BOSTA) && basla_i;
        okuma       = (durum_q == OKU) && ((fifo_fill + {1'b0, inflight_q}) < 2'd2)
                      && (word_idx_q < WC_W'(W));
        yukle       = (durum_q == OKU) && !stal_i && !fifo_bos;
        fifo_pop    = yukle && ((byte_idx_q == 2'd3) || (pix_cnt_q == PC_W'(N - 1)));
        son_tuketim = etkin_q && !stal_i && (pix_cnt_q == PC_W'(N));
    end

    always_comb begin
        base_d     = base_q;
        word_idx_d = word_idx_q;
        inflight_d = okuma;
        byte_idx_d = byte_idx_q;
        pix_cnt_d  = pix_cnt_q;
        etkin_d    = etkin_q;
        pixel_d    = pixel_q;
        if (basla_kabul) begin
            base_d     = taban_adr_i;
            word_idx_d = '0;
            byte_idx_d = '0;
            pix_cnt_d  = '0;
        end
        if (okuma) begin
            word_idx_d = word_idx_q + WC_W'(1);
        end
        if (yukle) begin
            etkin_d    = 1'b1;
            pixel_d    = fifo_bas[PIXEL_W*byte_idx_q +: PIXEL_W];
            pix_cnt_d  = pix_cnt_q + PC_W'(1);
            byte_idx_d = fifo_pop ? 2'd0 : byte_idx_q + 2'd1;
        end else if (!stal_i) begin
            etkin_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            base_q     <= '0;
            word_idx_q <= '0;
            inflight_q <= 1'b0;
            byte_idx_q <= '0;
            pix_cnt_q  <= '0;
            etkin_q    <= 1'b0;
            pixel_q    <= '0;
        end else begin
            base_q     <= base_d;
            word_idx_q <= word_idx_d;
            inflight_q <= inflight_d;
            byte_idx_q <= byte_idx_d;
            pix_cnt_q  <= pix_cnt_d;
            etkin_q    <= etkin_d;
            pixel_q    <= pixel_d;
        end
    end

`ifdef PIXEL_OKUYUCU_SATIR_ISARET_EN
    localparam int unsigned CC_W = $clog2(GENISLIK + 1);

    logic [CC_W-1:0] col_q, col_d;
    logic            satir_q, satir_d;

    always_comb begin
        col_d   = col_q;
        satir_d = satir_q;
        if (basla_kabul) begin
            col_d = '0;
        end
        if (yukle) begin
            satir_d = (col_q == CC_W'(GENISLIK - 1));
            col_d   = satir_d ? '0 : col_q + CC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            col_q   <= '0;
            satir_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            satir_q <= satir_d;
        end
    end

    assign satir_sonu_o = satir_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            durum_q <= BOSTA;
        end else begin
            durum_q <= durum_d;
        end
    end

    always_comb begin
        durum_d = durum_q;
        unique case (durum_q)
            BOSTA:   if (basla_i) durum_d = OKU;
            OKU:     if (son_tuketim) durum_d = BITTI;
            BITTI:   durum_d = BOSTA;
            default: durum_d = BOSTA;
        endcase
    end

    always_comb begin
        mesgul_o = (durum_q == OKU);
        bitti_o  = (durum_q == BITTI);
        csb_o    = !okuma;
        addr_o   = base_q + ADR_W'(word_idx_q);
        etkin_o  = etkin_q;
        pixel_o  = pixel_q;
    end

endmodule

// File: tb/tb_piksel_okuyucu.sv
// Scoreboard bench for piksel_okuyucu: a 4x2 and a 3x3 instance, each fed by a one-cycle-latency SRAM model.
module tb_piksel_okuyucu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic        rstn;
    logic        a_basla, a_stal, a_csb, a_etkin, a_mesgul, a_bitti;
    logic [15:0] a_taban, a_addr;
    logic [31:0] a_dout;
    logic [7:0]  a_pixel;
    logic        b_basla, b_stal, b_csb, b_etkin, b_mesgul, b_bitti;
    logic [15:0] b_taban, b_addr;
    logic [31:0] b_dout;
    logic [7:0]  b_pixel;
`ifdef PIXEL_OKUYUCU_SATIR_ISARET_EN
    logic        a_satir, b_satir;
    logic        a_obs_satir[$];
`endif

    logic [31:0] a_mem [0:255];
    logic [31:0] b_mem [0:255];

    logic [7:0]  a_exp_pix[$], a_obs_pix[$], b_exp_pix[$], b_obs_pix[$];
    logic [15:0] a_exp_adr[$], a_obs_adr[$], b_exp_adr[$], b_obs_adr[$];
    int          a_bitti_n, b_bitti_n;

    piksel_okuyucu #(.GENISLIK(4), .YUKSEKLIK(2), .ADR_W(16), .PIXEL_W(8)) dut_a (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .basla_i     (a_basla),
        .taban_adr_i (a_taban),
        .stal_i      (a_stal),
        .csb_o       (a_csb),
        .addr_o      (a_addr),
        .dout_i      (a_dout),
        .etkin_o     (a_etkin),
        .pixel_o     (a_pixel),
        .mesgul_o    (a_mesgul),
`ifdef PIXEL_OKUYUCU_SATIR_ISARET_EN
        .satir_sonu_o(a_satir),
`endif
        .bitti_o     (a_bitti)
    );

    piksel_okuyucu #(.GENISLIK(3), .YUKSEKLIK(3), .ADR_W(16), .PIXEL_W(8)) dut_b (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .basla_i     (b_basla),
        .taban_adr_i (b_taban),
        .stal_i      (b_stal),
        .csb_o       (b_csb),
        .addr_o      (b_addr),
        .dout_i      (b_dout),
        .etkin_o     (b_etkin),
        .pixel_o     (b_pixel),
        .mesgul_o    (b_mesgul),
`ifdef PIXEL_OKUYUCU_SATIR_ISARET_EN
        .satir_sonu_o(b_satir),
`endif
        .bitti_o     (b_bitti)
    );

    // SRAM models: data valid the cycle after a chip-select sample.
    always @(posedge clk) begin
        if (!a_csb) a_dout <= a_mem[a_addr[7:0]];
        if (!b_csb) b_dout <= b_mem[b_addr[7:0]];
    end

    always @(negedge clk) begin
        if (a_etkin && !a_stal) begin
            a_obs_pix.push_back(a_pixel);
`ifdef PIXEL_OKUYUCU_SATIR_ISARET_EN
            a_obs_satir.push_back(a_satir);
`endif
        end
        if (!a_csb) a_obs_adr.push_back(a_addr);
        if (a_bitti) a_bitti_n++;
        if (b_etkin && !b_stal) b_obs_pix.push_back(b_pixel);
        if (!b_csb) b_obs_adr.push_back(b_addr);
        if (b_bitti) b_bitti_n++;
    end

    task automatic clear_a();
        a_obs_pix.delete(); a_obs_adr.delete(); a_exp_pix.delete(); a_exp_adr.delete();
        a_bitti_n = 0;
`ifdef PIXEL_OKUYUCU_SATIR_ISARET_EN
        a_obs_satir.delete();
`endif
    endtask

    task automatic expect_a_image();
        for (int i = 0; i < 8; i++) a_exp_pix.push_back(8'(i));
        a_exp_adr.push_back(16'h0010);
        a_exp_adr.push_back(16'h0011);
    endtask

    task automatic start_a(input logic [15:0] base);
        @(posedge clk); #1;
        a_taban = base; a_basla = 1'b1;
        @(posedge clk); #1;
        a_basla = 1'b0;
    endtask

    task automatic start_b(input logic [15:0] base);
        @(posedge clk); #1;
        b_taban = base; b_basla = 1'b1;
        @(posedge clk); #1;
        b_basla = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({a_etkin, a_csb, a_mesgul, a_bitti} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, expected 0100", {a_etkin, a_csb, a_mesgul, a_bitti});
        end
        vectors++;
        if ({a_pixel, a_addr} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h, expected 000000", {a_pixel, a_addr});
        end
        vectors++;
        if ({b_etkin, b_csb, b_mesgul, b_bitti} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_ctrl_b: got %b, expected 0100", {b_etkin, b_csb, b_mesgul, b_bitti});
        end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_stream_4x2();
        int first_k, bitti_k, etkin_n;
        logic [7:0] e8;
        logic [15:0] g16, e16;
        clear_a();
        expect_a_image();
        start_a(16'h0010);
        first_k = -1; bitti_k = -1; etkin_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                vectors++;
                if (a_mesgul !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_mesgul: got %b, expected 1", a_mesgul);
                end
            end
            if (a_etkin) begin
                if (first_k < 0) first_k = k;
                etkin_n++;
            end
            if (a_bitti && bitti_k < 0) bitti_k = k;
        end
        vectors++;
        if (first_k != 3) begin miscompares++; $display("FAIL stream_latency: got %0d, expected 3", first_k); end
        vectors++;
        if (etkin_n != 8) begin miscompares++; $display("FAIL stream_valid_cycles: got %0d, expected 8", etkin_n); end
        vectors++;
        if (bitti_k != 11) begin miscompares++; $display("FAIL stream_bitti_cycle: got %0d, expected 11", bitti_k); end
        vectors++;
        if (a_bitti_n != 1) begin miscompares++; $display("FAIL stream_bitti_count: got %0d, expected 1", a_bitti_n); end
        vectors++;
        if (a_mesgul !== 1'b0) begin miscompares++; $display("FAIL stream_idle: got %b, expected 0", a_mesgul); end
        while (a_exp_pix.size() > 0) begin
            e8 = a_exp_pix.pop_front();
            g16 = (a_obs_pix.size() > 0) ? {8'h00, a_obs_pix.pop_front()} : 16'hFFFF;
            vectors++;
            if (g16 !== {8'h00, e8}) begin miscompares++; $display("FAIL stream_pixel: got %h, expected %h", g16, e8); end
        end
        vectors++;
        if (a_obs_pix.size() != 0) begin miscompares++; $display("FAIL stream_extra_pixels: got %0d, expected 0", a_obs_pix.size()); end
        while (a_exp_adr.size() > 0) begin
            e16 = a_exp_adr.pop_front();
            g16 = (a_obs_adr.size() > 0) ? a_obs_adr.pop_front() : 16'hFFFF;
            vectors++;
            if (g16 !== e16) begin miscompares++; $display("FAIL stream_addr: got %h, expected %h", g16, e16); end
        end
        vectors++;
        if (a_obs_adr.size() != 0) begin miscompares++; $display("FAIL stream_extra_reads: got %0d, expected 0", a_obs_adr.size()); end
    endtask

    task automatic test_partial_word();
        logic [7:0] e8;
        logic [15:0] g16, e16;
        b_obs_pix.delete(); b_obs_adr.delete(); b_bitti_n = 0;
        for (int i = 0; i < 8; i++) b_exp_pix.push_back(8'(i));
        b_exp_pix.push_back(8'hAA);
        for (int i = 0; i < 3; i++) b_exp_adr.push_back(16'h0020 + 16'(i));
        start_b(16'h0020);
        repeat (25) @(negedge clk);
        vectors++;
        if (b_bitti_n != 1) begin miscompares++; $display("FAIL partial_bitti_count: got %0d, expected 1", b_bitti_n); end
        while (b_exp_pix.size() > 0) begin
            e8 = b_exp_pix.pop_front();
            g16 = (b_obs_pix.size() > 0) ? {8'h00, b_obs_pix.pop_front()} : 16'hFFFF;
            vectors++;
            if (g16 !== {8'h00, e8}) begin miscompares++; $display("FAIL partial_pixel: got %h, expected %h", g16, e8); end
        end
        vectors++;
        if (b_obs_pix.size() != 0) begin miscompares++; $display("FAIL partial_extra_pixels: got %0d, expected 0", b_obs_pix.size()); end
        while (b_exp_adr.size() > 0) begin
            e16 = b_exp_adr.pop_front();
            g16 = (b_obs_adr.size() > 0) ? b_obs_adr.pop_front() : 16'hFFFF;
            vectors++;
            if (g16 !== e16) begin miscompares++; $display("FAIL partial_addr: got %h, expected %h", g16, e16); end
        end
        vectors++;
        if (b_obs_adr.size() != 0) begin miscompares++; $display("FAIL partial_extra_reads: got %0d, expected 0", b_obs_adr.size()); end
    endtask

    task automatic test_stall();
        logic [7:0] e8;
        logic [15:0] g16;
        b_obs_pix.delete(); b_obs_adr.delete(); b_bitti_n = 0;
        for (int i = 0; i < 8; i++) b_exp_pix.push_back(8'(i));
        b_exp_pix.push_back(8'hAA);
        start_b(16'h0020);
        repeat (5) @(posedge clk);
        #1 b_stal = 1'b1;
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if ({b_etkin, b_pixel} !== 9'h102) begin
                miscompares++;
                $display("FAIL stall_hold: got %h, expected 102", {b_etkin, b_pixel});
            end
            vectors++;
            if (b_obs_adr.size() > 2) begin
                miscompares++;
                $display("FAIL stall_buffered: got %0d reads, expected at most 2", b_obs_adr.size());
            end
        end
        @(posedge clk); #1;
        b_stal = 1'b0;
        repeat (30) @(negedge clk);
        vectors++;
        if (b_bitti_n != 1) begin miscompares++; $display("FAIL stall_bitti_count: got %0d, expected 1", b_bitti_n); end
        vectors++;
        if (b_obs_adr.size() != 3) begin miscompares++; $display("FAIL stall_reads: got %0d, expected 3", b_obs_adr.size()); end
        while (b_exp_pix.size() > 0) begin
            e8 = b_exp_pix.pop_front();
            g16 = (b_obs_pix.size() > 0) ? {8'h00, b_obs_pix.pop_front()} : 16'hFFFF;
            vectors++;
            if (g16 !== {8'h00, e8}) begin miscompares++; $display("FAIL stall_pixel: got %h, expected %h", g16, e8); end
        end
        vectors++;
        if (b_obs_pix.size() != 0) begin miscompares++; $display("FAIL stall_extra_pixels: got %0d, expected 0", b_obs_pix.size()); end
    endtask

    task automatic test_basla_ignored();
        logic [7:0] e8;
        logic [15:0] g16, e16;
        clear_a();
        expect_a_image();
        start_a(16'h0010);
        repeat (3) @(posedge clk);
        #1 a_taban = 16'h0080; a_basla = 1'b1;
        @(negedge clk);
        vectors++;
        if (a_mesgul !== 1'b1) begin miscompares++; $display("FAIL ignore_mesgul: got %b, expected 1", a_mesgul); end
        @(posedge clk); #1;
        a_basla = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (a_bitti_n != 1) begin miscompares++; $display("FAIL ignore_bitti_count: got %0d, expected 1", a_bitti_n); end
        while (a_exp_pix.size() > 0) begin
            e8 = a_exp_pix.pop_front();
            g16 = (a_obs_pix.size() > 0) ? {8'h00, a_obs_pix.pop_front()} : 16'hFFFF;
            vectors++;
            if (g16 !== {8'h00, e8}) begin miscompares++; $display("FAIL ignore_pixel: got %h, expected %h", g16, e8); end
        end
        vectors++;
        if (a_obs_pix.size() != 0) begin miscompares++; $display("FAIL ignore_extra_pixels: got %0d, expected 0", a_obs_pix.size()); end
        while (a_exp_adr.size() > 0) begin
            e16 = a_exp_adr.pop_front();
            g16 = (a_obs_adr.size() > 0) ? a_obs_adr.pop_front() : 16'hFFFF;
            vectors++;
            if (g16 !== e16) begin miscompares++; $display("FAIL ignore_addr: got %h, expected %h", g16, e16); end
        end
        vectors++;
        if (a_obs_adr.size() != 0) begin miscompares++; $display("FAIL ignore_extra_reads: got %0d, expected 0", a_obs_adr.size()); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e8;
        logic [15:0] g16;
        clear_a();
        start_a(16'h0010);
        repeat (5) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({a_etkin, a_csb, a_mesgul, a_bitti} !== 4'b0100) begin
            miscompares++;
            $display("FAIL midreset_ctrl: got %b, expected 0100", {a_etkin, a_csb, a_mesgul, a_bitti});
        end
        vectors++;
        if ({a_pixel, a_addr} !== 24'h0) begin
            miscompares++;
            $display("FAIL midreset_data: got %h, expected 000000", {a_pixel, a_addr});
        end
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        clear_a();
        expect_a_image();
        start_a(16'h0010);
        repeat (20) @(negedge clk);
        vectors++;
        if (a_bitti_n != 1) begin miscompares++; $display("FAIL midreset_bitti_count: got %0d, expected 1", a_bitti_n); end
        vectors++;
        if (a_obs_adr.size() != 2) begin miscompares++; $display("FAIL midreset_reads: got %0d, expected 2", a_obs_adr.size()); end
        while (a_exp_pix.size() > 0) begin
            e8 = a_exp_pix.pop_front();
            g16 = (a_obs_pix.size() > 0) ? {8'h00, a_obs_pix.pop_front()} : 16'hFFFF;
            vectors++;
            if (g16 !== {8'h00, e8}) begin miscompares++; $display("FAIL midreset_pixel: got %h, expected %h", g16, e8); end
        end
        vectors++;
        if (a_obs_pix.size() != 0) begin miscompares++; $display("FAIL midreset_extra_pixels: got %0d, expected 0", a_obs_pix.size()); end
    endtask

`ifdef PIXEL_OKUYUCU_SATIR_ISARET_EN
    task automatic test_satir();
        logic exp_satir[$];
        logic e1;
        logic [1:0] g2;
        clear_a();
        for (int i = 0; i < 8; i++) exp_satir.push_back((i % 4) == 3);
        start_a(16'h0010);
        repeat (20) @(negedge clk);
        while (exp_satir.size() > 0) begin
            e1 = exp_satir.pop_front();
            g2 = (a_obs_satir.size() > 0) ? {1'b0, a_obs_satir.pop_front()} : 2'b11;
            vectors++;
            if (g2 !== {1'b0, e1}) begin miscompares++; $display("FAIL satir_sonu: got %b, expected %b", g2, e1); end
        end
        vectors++;
        if (a_obs_satir.size() != 0) begin miscompares++; $display("FAIL satir_extra: got %0d, expected 0", a_obs_satir.size()); end
    endtask
`endif

    initial begin
        rstn = 1'b0;
        a_basla = 1'b0; a_stal = 1'b0; a_taban = '0;
        b_basla = 1'b0; b_stal = 1'b0; b_taban = '0;
        a_bitti_n = 0; b_bitti_n = 0;
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = 32'hEEEE_0000 | 32'(i);
            b_mem[i] = 32'hEEEE_0000 | 32'(i);
        end
        a_mem[8'h10] = 32'h0302_0100;
        a_mem[8'h11] = 32'h0706_0504;
        a_mem[8'h80] = 32'hDEAD_BEEF;
        b_mem[8'h20] = 32'h0302_0100;
        b_mem[8'h21] = 32'h0706_0504;
        b_mem[8'h22] = 32'hDDCC_BBAA;

        test_reset();
        test_stream_4x2();
        test_partial_word();
        test_stall();
        test_basla_ignored();
        test_reset_mid();
`ifdef PIXEL_OKUYUCU_SATIR_ISARET_EN
        test_satir();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
